// File: rtl/sealed_bid_auction_seq_if.sv
// Handshake bundle between the bid-ingest stage, the auction block and the result sink.
interface sealed_bid_auction_seq_if #(
  parameter int N_LOG = 2,
  parameter int W     = 16
);
  logic             start;
  logic             mode_2nd;
  logic             bid_valid;
  logic             bid_ready;
  logic [W-1:0]     bid_data;
  logic [N_LOG-1:0] bid_idx;
  logic             res_valid;
  logic             res_ready;
  logic [N_LOG-1:0] winner_idx;
  logic [W-1:0]     win_bid;
  logic [W-1:0]     pay_price;
  logic             busy;

  // Upstream/downstream side: issues auctions, bids and result acceptance.
  modport master (
    output start, mode_2nd, bid_valid, bid_data, res_ready,
    input  bid_ready, bid_idx, res_valid, winner_idx, win_bid, pay_price, busy
  );

  // Auction block side.
  modport slave (
    input  start, mode_2nd, bid_valid, bid_data, res_ready,
    output bid_ready, bid_idx, res_valid, winner_idx, win_bid, pay_price, busy
  );
endinterface

// File: rtl/sealed_bid_auction_seq.sv
// Sequential sealed-bid auction: streams NB bids in index order, tracks top two,
// reports winner with first-price or second-price (Vickrey) payment.
module sealed_bid_auction_seq #(
  parameter int N_LOG = 2,
  parameter int W     = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  sealed_bid_auction_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t           state, state_nxt;
  logic [N_LOG-1:0] count;
  logic [N_LOG-1:0] win_q;
  logic [W-1:0]     max_q;
  logic [W-1:0]     sec_q;
  logic             mode_q;
  logic             res_valid_q;
  logic             busy_q;
  logic             accept;
  logic             last_bid;
  logic             launch;

  assign last_bid = &count;

  always_comb begin
    state_nxt     = state;
    accept        = 1'b0;
    launch        = 1'b0;
    bus.bid_ready = 1'b0;
    bus.bid_idx   = '0;
    case (state)
      IDLE: begin
        launch = bus.start;
        if (bus.start) state_nxt = COLLECT;
      end
      COLLECT: begin
        bus.bid_ready = 1'b1;
        bus.bid_idx   = count;
        accept        = bus.bid_valid;
        if (bus.bid_valid && last_bid) state_nxt = DONE;
      end
      DONE: begin
        if (bus.res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state       <= state_nxt;
      res_valid_q <= (state_nxt == DONE);
      busy_q      <= (state_nxt != IDLE);
    end
  end

  // Strict '>' against max keeps the lowest index on ties; a tied max falls
  // through to the second-place compare so second ends up equal to max.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      win_q  <= '0;
      max_q  <= '0;
      sec_q  <= '0;
      mode_q <= 1'b0;
    end else if (launch) begin
      count  <= '0;
      win_q  <= '0;
      max_q  <= '0;
      sec_q  <= '0;
      mode_q <= bus.mode_2nd;
    end else if (accept) begin
      if (!last_bid) count <= count + 1'b1;
      if (bus.bid_data > max_q) begin
        sec_q <= max_q;
        max_q <= bus.bid_data;
        win_q <= count;
      end else if (bus.bid_data > sec_q) begin
        sec_q <= bus.bid_data;
      end
    end
  end

  assign bus.res_valid  = res_valid_q;
  assign bus.busy       = busy_q;
  assign bus.winner_idx = win_q;
  assign bus.win_bid    = max_q;
  assign bus.pay_price  = mode_q ? sec_q : max_q;
endmodule
